mfp_ahb_lite_interconnect: RTL
==============================

# mfp_ahb_lite_interconnect

Parametrised single-master AHB-Lite interconnect core for the MIPSfpga+ system bus. It decodes HADDR against N configurable address windows and drives one-hot slave selects. It registers the data-phase owner and muxes HREADYOUT/HRDATA/HRESP back to the core. An internal default slave answers unmapped accesses with a proper two-cycle ERROR, and an optional watchdog aborts hung slaves.

## Interface
- N_SLAVES, 4: number of slave ports, 1..16.
- SLAVE_BASE, {N_SLAVES{32'h0}}: flattened N_SLAVES×32 base addresses; slave i at [32*i+:32].
- SLAVE_MASK, {N_SLAVES{32'h0}}: flattened N_SLAVES×32 compare masks; slave i matches when (HADDR & mask_i) == (base_i & mask_i).
- TIMEOUT_CYCLES, 1024: stall limit in cycles, ≥4; used only with MFP_AHB_LITE_TIMEOUT_EN.

Ports (one clock; reset is asynchronous and active-low):
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type.
- HREADY  out  1  to master and broadcast to all slaves as their HREADY input.
- HRDATA  out  32  read data to master.
- HRESP  out  1  response to master (0 OKAY, 1 ERROR).
- HSEL_S  out  N_SLAVES  one-hot address-phase selects.
- HREADYOUT_S  in  N_SLAVES  per-slave ready.
- HRDATA_S  in  32*N_SLAVES  per-slave read data.
- HRESP_S  in  N_SLAVES  per-slave response.
- TIMEOUT_FLAG  out  1  sticky watchdog flag.
- TIMEOUT_SLAVE  out  4  index of slave that timed out.

All other master signals (HWRITE, HSIZE, HWDATA, …) fan out to slaves directly, outside this block.

## Operation
- Decode (combinational): match_i per mask compare. Overlaps resolved by lowest index. HSEL_S is the one-hot of the winner, not gated by HTRANS. No match → HSEL_S = 0, default slave selected.
- Data-phase register dsel (N_SLAVES+1 one-hot incl. default, plus dact). Loaded only when HREADY = 1: dsel ← decode, dact ← HTRANS[1] (NONSEQ/SEQ).
- Response mux:
  - dact = 0 → HREADY = 1, HRESP = 0, HRDATA = 0.
  - dact = 1, real slave k → HREADY = HREADYOUT_S[k], HRESP = HRESP_S[k], HRDATA = HRDATA_S[k].
  - dact = 1, default slave → HRDATA = 0; ERROR sequence below.
- Default-slave FSM: IDLE → ERR1 (HREADY = 0, HRESP = 1) → ERR2 (HREADY = 1, HRESP = 1) → IDLE or ERR1 if the next accepted transfer is also unmapped and active. IDLE/BUSY to unmapped space → zero-wait OKAY.
- Master changing HTRANS/HADDR during ERR1 is legal; only the value sampled with HREADY = 1 is used.
- Reset (async): dsel = none, dact = 0, FSM = IDLE, HREADY = 1, HRESP = 0, HRDATA = 0, TIMEOUT_FLAG = 0, TIMEOUT_SLAVE = 0. Reset mid-transfer abandons the data phase without response.

## Timing
- Address → select: 0 cycles (combinational HSEL_S).
- Data phase begins the cycle after the address is accepted (HREADY = 1 at the clock edge).
- Mapped slave: latency equals slave wait states; HREADY passes combinationally from HREADYOUT_S.
- Unmapped active transfer: exactly 2 data-phase cycles (ERR1, ERR2).
- Back-to-back transfers to different slaves: no bubble; dsel switches on the same edge the new address is accepted.

## Configuration
- MFP_AHB_LITE_TIMEOUT_EN defined: a 16-bit counter clears whenever HREADY = 1 or dact = 0. It increments while a real slave holds HREADYOUT low. On reaching TIMEOUT_CYCLES−1, the block overrides the slave and issues ERR1/ERR2 to the master, then treats the data phase as complete. It also sets TIMEOUT_FLAG (sticky until reset) and latches TIMEOUT_SLAVE = k. The slave is left undefined; this is a debug feature.
- Not defined: no counter is built, slaves may stall indefinitely, and TIMEOUT_FLAG and TIMEOUT_SLAVE are tied to 0.

## Test plan
- N_SLAVES = 4 with the standard map (reset RAM 0x1FC00000/mask 0x1FC00000, RAM 0x0/0x1C000000, GPIO 0x1F800000/0x1FC00000, UART 0x10401000/0x1FFFF000). NONSEQ read 0x1F800004 → HSEL_S = 4'b0100; next cycle HRDATA = HRDATA_S[2], HRESP = 0.
- Slave 1 holds HREADYOUT low 3 cycles during a read of 0x00000010 → HREADY low exactly 3 cycles, dsel stable, and the pipelined next address is not accepted until release.
- NONSEQ read 0x12000000 (unmapped) → ERR1 cycle (HREADY = 0, HRESP = 1), then ERR2 (HREADY = 1, HRESP = 1), then OKAY. An IDLE to the same address gives zero-wait OKAY.
- Back-to-back NONSEQ to RAM, GPIO, unmapped, UART → correct per-cycle data source, one 2-cycle error, no extra bubbles.
- Assert HRESETn low during slave 1's wait state → HREADY = 1, HRESP = 0, HRDATA = 0 immediately (async); first post-reset transfer completes normally.
- With MFP_AHB_LITE_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave 3 stalls forever → ERR1 starts after the 8th stalled cycle, then ERR2. TIMEOUT_FLAG = 1 and TIMEOUT_SLAVE = 3 persist until reset.

Source files
------------

// File: rtl/mfp_ahb_lite_interconnect_if.sv
// AHB-Lite bus bundle between one master, the interconnect and N slaves.
// The master modport is the core's view; the slave modport is the interconnect's view of both sides.
interface mfp_ahb_lite_interconnect_if #(
  parameter int N_SLAVES = 4
);
  logic [31:0]             HADDR;
  logic [1:0]              HTRANS;
  logic                    HREADY;
  logic [31:0]             HRDATA;
  logic                    HRESP;
  logic [N_SLAVES-1:0]     HSEL_S;
  logic [N_SLAVES-1:0]     HREADYOUT_S;
  logic [32*N_SLAVES-1:0]  HRDATA_S;
  logic [N_SLAVES-1:0]     HRESP_S;

  modport master (
    output HADDR, HTRANS,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    input  HADDR, HTRANS,
    output HREADY, HRDATA, HRESP,
    output HSEL_S,
    input  HREADYOUT_S, HRDATA_S, HRESP_S
  );
endinterface

// File: rtl/mfp_ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: window decode, data-phase mux, default ERROR slave.
// Optional slave watchdog enabled by defining MFP_AHB_LITE_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no error in progress; response comes from dsel/dact
// ST_ERR1  | first ERROR cycle (HREADY=0, HRESP=1): unmapped or timed out
// ST_ERR2  | second ERROR cycle (HREADY=1, HRESP=1); next address accepted
module mfp_ahb_lite_interconnect #(
  parameter int                     N_SLAVES       = 4,
  parameter logic [32*N_SLAVES-1:0] SLAVE_BASE     = {N_SLAVES{32'h0}},
  parameter logic [32*N_SLAVES-1:0] SLAVE_MASK     = {N_SLAVES{32'h0}},
  parameter int                     TIMEOUT_CYCLES = 1024
) (
  input  logic                              HCLK,
  input  logic                              HRESETn,
  mfp_ahb_lite_interconnect_if.slave        bus,
  output logic                              TIMEOUT_FLAG,
  output logic [3:0]                        TIMEOUT_SLAVE
);

  if (N_SLAVES < 1 || N_SLAVES > 16 || TIMEOUT_CYCLES < 4) begin : g_bad_cfg
    $error("mfp_ahb_lite_interconnect: illegal N_SLAVES or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} err_state_t;

  err_state_t            state;
  logic [N_SLAVES-1:0]   hsel;
  logic                  hit;
  logic [N_SLAVES:0]     dsel;
  logic                  dact;
  logic                  unmapped_active;
  logic                  timeout;
  logic                  slv_ready;
  logic                  slv_resp;
  logic [31:0]           slv_rdata;

  // Lowest index wins when windows overlap.
  always_comb begin
    hsel = '0;
    hit  = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!hit && ((bus.HADDR & SLAVE_MASK[32*i +: 32]) ==
                   (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32]))) begin
        hsel[i] = 1'b1;
        hit     = 1'b1;
      end
    end
  end

  assign bus.HSEL_S      = hsel;
  assign unmapped_active = bus.HREADY & bus.HTRANS[1] & ~hit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel <= '0;
      dact <= 1'b0;
    end else if (bus.HREADY) begin
      dsel <= {~hit, hsel};
      dact <= bus.HTRANS[1];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (unmapped_active || timeout) state <= ST_ERR1;
        ST_ERR1: state <= ST_ERR2;
        ST_ERR2: state <= unmapped_active ? ST_ERR1 : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    slv_ready = 1'b1;
    slv_resp  = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (dsel[i]) begin
        slv_ready = bus.HREADYOUT_S[i];
        slv_resp  = bus.HRESP_S[i];
        slv_rdata = bus.HRDATA_S[32*i +: 32];
      end
    end
  end

  // Error states override whichever slave owns the data phase.
  always_comb begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = '0;
    if (state == ST_ERR1) begin
      bus.HREADY = 1'b0;
      bus.HRESP  = 1'b1;
    end else if (state == ST_ERR2) begin
      bus.HRESP  = 1'b1;
    end else if (dact && !dsel[N_SLAVES]) begin
      bus.HREADY = slv_ready;
      bus.HRESP  = slv_resp;
      bus.HRDATA = slv_rdata;
    end
  end

`ifdef MFP_AHB_LITE_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic [3:0]  dsel_idx;
  logic        stalled;

  assign stalled = dact & ~dsel[N_SLAVES] & (state == ST_IDLE) & ~bus.HREADY;
  assign timeout = stalled & (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    dsel_idx = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (dsel[i]) dsel_idx = 4'(i);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      to_cnt        <= '0;
      TIMEOUT_FLAG  <= 1'b0;
      TIMEOUT_SLAVE <= '0;
    end else begin
      to_cnt <= stalled ? to_cnt + 16'd1 : 16'd0;
      if (timeout) begin
        TIMEOUT_FLAG  <= 1'b1;
        TIMEOUT_SLAVE <= dsel_idx;
      end
    end
  end
`else
  assign timeout       = 1'b0;
  assign TIMEOUT_FLAG  = 1'b0;
  assign TIMEOUT_SLAVE = '0;
`endif

endmodule
